// File: rtl/pong_ball_ctrl_if.sv
// Signal bundle between the pong ball controller and the frame/bar logic around it.
// The master side is the ball controller itself.
interface pong_ball_ctrl_if;
    logic       frame_tick;
    logic       serve;
    logic [6:0] bar_x;
    logic [6:0] bar_y;
    logic [6:0] ball_x;
    logic [6:0] ball_y;
    logic [7:0] score;
    logic [1:0] lives;
    logic [1:0] state;
    logic       hit;
    logic       miss;

    modport master (
        input  frame_tick, serve, bar_x, bar_y,
        output ball_x, ball_y, score, lives, state, hit, miss
    );

    modport slave (
        output frame_tick, serve, bar_x, bar_y,
        input  ball_x, ball_y, score, lives, state, hit, miss
    );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Pong ball controller: serves from the bar, steps the ball every SPEED frames,
// bounces off walls and bar, and tracks score and lives.
module pong_ball_ctrl #(
    parameter int GRID_W    = 64,
    parameter int GRID_H    = 48,
    parameter int BAR_LEN   = 6,
    parameter int SPEED     = 4,
    parameter int MISS_HOLD = 60,
    parameter int LIVES     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    pong_ball_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [6:0]  X_RESET    = 7'(GRID_W / 2);
    localparam logic [6:0]  Y_RESET    = 7'(GRID_H - 2);
    localparam logic [6:0]  X_LAST     = 7'(GRID_W - 2);
    localparam logic [6:0]  Y_BOTTOM   = 7'(GRID_H - 1);
    localparam logic [6:0]  BAR_MID    = 7'(BAR_LEN / 2);
    localparam logic [7:0]  BAR_SPAN   = 8'(BAR_LEN - 1);
    localparam logic [7:0]  STEP_LAST  = 8'(SPEED - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(MISS_HOLD - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

    state_t      cur_state, nxt_state;
    logic [6:0]  ball_x, ball_x_n;
    logic [6:0]  ball_y, ball_y_n;
    logic        dir_right, dir_right_n;
    logic        dir_up, dir_up_n;
    logic [7:0]  score, score_n;
    logic [1:0]  lives, lives_n;
    logic [7:0]  step_cnt, step_cnt_n;
    logic [15:0] hold_cnt, hold_cnt_n;
    logic        hit, hit_n;
    logic        miss, miss_n;
    logic        on_bar;

    // Bar test uses the ball position before the step; 8-bit compare avoids wrap at the right edge.
    assign on_bar = (ball_y + 7'd1 == bus.bar_y)
                 && ({1'b0, bus.bar_x} <= {1'b0, ball_x})
                 && ({1'b0, ball_x} <= {1'b0, bus.bar_x} + BAR_SPAN);

    always_comb begin
        // NOTE: every next value defaults to the current one first, so no path leaves a latch.
        nxt_state   = cur_state;
        ball_x_n    = ball_x;
        ball_y_n    = ball_y;
        dir_right_n = dir_right;
        dir_up_n    = dir_up;
        score_n     = score;
        lives_n     = lives;
        step_cnt_n  = step_cnt;
        hold_cnt_n  = hold_cnt;
        hit_n       = 1'b0;
        miss_n      = 1'b0;

        if (bus.frame_tick) begin
            case (cur_state)
                IDLE: begin
                    ball_x_n    = bus.bar_x + BAR_MID;
                    ball_y_n    = (bus.bar_y == 7'd0) ? 7'd0 : bus.bar_y - 7'd1;
                    dir_right_n = 1'b1;
                    dir_up_n    = 1'b1;
                    if (bus.serve) begin
                        nxt_state  = RUN;
                        step_cnt_n = 8'd0;
                    end
                end

                RUN: begin
                    if (step_cnt != STEP_LAST) begin
                        step_cnt_n = step_cnt + 8'd1;
                    end else begin
                        step_cnt_n = 8'd0;

                        if (dir_right && ball_x == X_LAST) begin
                            dir_right_n = 1'b0;
                            ball_x_n    = ball_x - 7'd1;
                        end else if (!dir_right && ball_x == 7'd1) begin
                            dir_right_n = 1'b1;
                            ball_x_n    = ball_x + 7'd1;
                        end else begin
                            ball_x_n = dir_right ? ball_x + 7'd1 : ball_x - 7'd1;
                        end

                        if (dir_up) begin
                            if (ball_y == 7'd0) begin
                                dir_up_n = 1'b0;
                                ball_y_n = 7'd1;
                            end else begin
                                ball_y_n = ball_y - 7'd1;
                            end
                        end else if (on_bar) begin
                            dir_up_n = 1'b1;
                            ball_y_n = ball_y - 7'd1;
                            score_n  = score + 8'd1;
                            hit_n    = 1'b1;
                        end else if (ball_y == Y_BOTTOM) begin
                            // Lost ball freezes in place, undoing the horizontal move.
                            ball_x_n    = ball_x;
                            dir_right_n = dir_right;
                            miss_n      = 1'b1;
                            lives_n     = lives - 2'd1;
                            if (lives == 2'd1) begin
                                nxt_state = OVER;
                            end else begin
                                nxt_state  = MISS;
                                hold_cnt_n = 16'd0;
                            end
                        end else begin
                            ball_y_n = ball_y + 7'd1;
                        end
                    end
                end

                MISS: begin
                    if (hold_cnt == HOLD_LAST) begin
                        nxt_state  = IDLE;
                        hold_cnt_n = 16'd0;
                    end else begin
                        hold_cnt_n = hold_cnt + 16'd1;
                    end
                end

                OVER: begin
                    if (bus.serve) begin
                        lives_n   = LIVES_INIT;
                        score_n   = 8'd0;
                        nxt_state = IDLE;
                    end
                end

                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            ball_x    <= X_RESET;
            ball_y    <= Y_RESET;
            dir_right <= 1'b1;
            dir_up    <= 1'b1;
            score     <= 8'd0;
            lives     <= LIVES_INIT;
            step_cnt  <= 8'd0;
            hold_cnt  <= 16'd0;
            hit       <= 1'b0;
            miss      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update from the same pre-edge values.
            cur_state <= nxt_state;
            ball_x    <= ball_x_n;
            ball_y    <= ball_y_n;
            dir_right <= dir_right_n;
            dir_up    <= dir_up_n;
            score     <= score_n;
            lives     <= lives_n;
            step_cnt  <= step_cnt_n;
            hold_cnt  <= hold_cnt_n;
            hit       <= hit_n;
            miss      <= miss_n;
        end
    end

    assign bus.ball_x = ball_x;
    assign bus.ball_y = ball_y;
    assign bus.score  = score;
    assign bus.lives  = lives;
    assign bus.state  = cur_state;
    assign bus.hit    = hit;
    assign bus.miss   = miss;
endmodule

// File: doc/pong_ball_ctrl.md
PONG_BALL_CTRL -- requirements
Module: pong_ball_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 64, playfield width in 10-px cells; wall columns are 0 and GRID_W-1.
REQ-002 SHALL have parameter GRID_H, default 48, playfield height in 10-px cells.
REQ-003 SHALL have parameter BAR_LEN, default 6, bar width in cells (60 px).
REQ-004 SHALL have parameter SPEED, default 4, frame ticks per ball step; legal range 1..255.
REQ-005 SHALL have parameter MISS_HOLD, default 60, frame ticks spent in MISS.
REQ-006 SHALL have parameter LIVES, default 3, lives loaded at reset and restart; legal range 1..3.
REQ-007 SHALL have port clk, input, 1, single system clock, all state on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port frame_tick, input, 1, one-clk pulse per video frame.
REQ-010 SHALL have port serve, input, 1, serve/restart request, level-sampled on frame_tick.
REQ-011 SHALL have port bar_x, input, 7, bar leftmost cell.
REQ-012 SHALL have port bar_y, input, 7, bar row.
REQ-013 SHALL have port ball_x, output, 7, ball cell column, registered.
REQ-014 SHALL have port ball_y, output, 7, ball cell row, registered.
REQ-015 SHALL have port score, output, 8, bar hits, registered.
REQ-016 SHALL have port lives, output, 2, lives remaining, registered.
REQ-017 SHALL have port state, output, 2, 0=IDLE 1=RUN 2=MISS 3=OVER.
REQ-018 SHALL have port hit, output, 1, one-clk pulse on bar bounce.
REQ-019 SHALL have port miss, output, 1, one-clk pulse on ball lost.

Function
REQ-020 All state SHALL update only in clk cycles with frame_tick=1; otherwise registers hold, and hit and miss are 0.
REQ-021 IDLE: each tick SHALL load ball_x=bar_x+BAR_LEN/2, ball_y=bar_y-1 (0 if bar_y=0), dir_x=+, dir_y=up; if serve=1 on that tick, state SHALL become RUN with step counter cleared.
REQ-022 RUN: a 8-bit step counter SHALL increment each tick; on the tick where it equals SPEED-1 it SHALL clear and one ball step SHALL occur.
REQ-023 Horizontal step: if dir_x=+ and ball_x=GRID_W-2, dir_x SHALL flip and ball_x SHALL decrement; if dir_x=- and ball_x=1, dir_x SHALL flip and ball_x SHALL increment; otherwise ball_x SHALL move one cell in dir_x.
REQ-024 Vertical step, up: if ball_y=0, dir_y SHALL flip to down and ball_y SHALL become 1; otherwise ball_y SHALL decrement.
REQ-025 Vertical step, down, bar hit (ball_y+1=bar_y and bar_x<=ball_x<=bar_x+BAR_LEN-1, ball_x before the step): dir_y SHALL flip to up, ball_y SHALL decrement, score SHALL increment modulo 256, and hit SHALL pulse one clk.
REQ-026 Vertical step, down, ball_y=GRID_H-1: ball SHALL freeze, miss SHALL pulse, and lives SHALL decrement; state SHALL become OVER if lives was 1, else MISS with hold counter cleared.
REQ-027 Otherwise, on a down step, ball_y SHALL increment.
REQ-028 Horizontal and vertical reflection in the same step (corner) SHALL both apply independently; a bar hit SHALL take priority over the bottom-row miss.
REQ-029 MISS: the hold counter SHALL count ticks; on tick MISS_HOLD-1 state SHALL become IDLE; serve SHALL be ignored.
REQ-030 OVER: the ball SHALL hold; serve=1 on a tick SHALL set lives=LIVES, score=0, and state=IDLE.
REQ-031 All outputs SHALL be registered; ball_x and ball_y SHALL reflect a step in the clk cycle after the stepping tick.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=IDLE, ball_x=GRID_W/2, ball_y=GRID_H-2, dir_x=+, dir_y=up, score=0, lives=LIVES, hit=0, miss=0, and both counters 0; this SHALL hold from any state, including mid-step.
REQ-033 After rst_n deasserts, the first action SHALL occur on the first frame_tick.

Verification
REQ-034 Reset, then tick with bar_x=20, bar_y=45, serve=0 -> ball=(23,44), state=0.
REQ-035 Serve, then 4 ticks (SPEED=4) -> ball=(24,43), state=1; ticks 1-3 change nothing.
REQ-036 Ball (62,10) moving +/up, step -> ball=(61,9), dir_x=-; ball (5,0) up, step -> ball_y=1, dir down.
REQ-037 Ball (22,44) down, bar_x=20, bar_y=45, step -> hit pulse, score 0->1, ball_y=43, dir up; repeat with bar_x=30 -> no hit.
REQ-038 Ball at row 47 down, lives=1 -> miss pulse, lives=0, state=3; serve tick -> lives=3, score=0, state=0.
REQ-039 rst_n asserted in RUN between ticks -> outputs at reset values immediately, no hit or miss pulse.
